// File: rtl/camera_dvp_pkg.sv
// rtl/camera_dvp_pkg.sv - shared types and default timing for the DVP transmitter
package camera_dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } dvp_state_t;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_H_BLANK     = 288;
    localparam int DEF_VSYNC_LINES = 3;
    localparam int DEF_V_BACK      = 17;
    localparam int DEF_V_FRONT     = 10;

    function automatic int line_len(input int h_active, input int h_blank);
        return 2 * h_active + h_blank;
    endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// rtl/dvp_timing_gen.sv - frame/line sequencer with pixel and line counters
module dvp_timing_gen
    import camera_dvp_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_FRONT     = DEF_V_FRONT
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    output dvp_state_t  state,
    output logic [11:0] hcnt,
    output logic [10:0] vcnt,
    output logic        line_end,
    output logic        frame_end
);

    localparam int LINE_LEN = line_len(H_ACTIVE, H_BLANK);

    dvp_state_t state_next;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // vcnt restarts on every state change so each phase counts its own lines
    always_ff @(posedge pclk) begin
        if (!rst_n || state == ST_IDLE) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= line_end ? 12'd0 : hcnt + 12'd1;
            if (state_next != state) begin
                vcnt <= '0;
            end else if (line_end) begin
                vcnt <= vcnt + 11'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (en) state_next = ST_VSYNC;
            ST_VSYNC:  if (line_end && vcnt == 11'(VSYNC_LINES - 1)) state_next = ST_VBACK;
            ST_VBACK:  if (line_end && vcnt == 11'(V_BACK - 1)) state_next = ST_ACTIVE;
            ST_ACTIVE: if (line_end && vcnt == 11'(V_ACTIVE - 1)) state_next = ST_VFRONT;
            ST_VFRONT: if (frame_end) state_next = en ? ST_VSYNC : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        line_end  = (state != ST_IDLE) && (hcnt == 12'(LINE_LEN - 1));
        frame_end = (state == ST_VFRONT) && line_end && (vcnt == 11'(V_FRONT - 1));
    end

endmodule

// File: rtl/camera_dvp_tx.sv
// rtl/camera_dvp_tx.sv - DVP camera-output emulator: byte serialiser, test pattern, underflow flag
module camera_dvp_tx
    import camera_dvp_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_FRONT     = DEF_V_FRONT
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        test_pattern,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_rd,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        frame_done,
    output logic        underflow
);

    dvp_state_t  state;
    logic [11:0] hcnt;
    logic [10:0] vcnt;
    logic        line_end;
    logic        frame_end;

    dvp_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .en        (en),
        .state     (state),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    logic        pattern_q;
    logic        frame_start;
    logic        in_active;
    logic        even_slot;
    logic        odd_slot;
    logic [15:0] pat_pix;
    logic [15:0] pix;
    logic [7:0]  lo;
    logic        unused_bits;

    assign frame_start = en && ((state == ST_IDLE) || frame_end);
    assign in_active   = (state == ST_ACTIVE) && (hcnt < 12'(2 * H_ACTIVE));
    assign even_slot   = in_active && !hcnt[0];
    assign odd_slot    = in_active && hcnt[0];
    assign pix_rd      = even_slot && !pattern_q;

    // pattern word: pixel index in line, active line index, pixel index again
    assign pat_pix = {hcnt[5:1], vcnt[5:0], hcnt[5:1]};
    assign pix     = pattern_q ? pat_pix : (pix_valid ? pix_data : 16'h0000);

    assign unused_bits = &{1'b0, vcnt[10:6], line_end};

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            vsync      <= 1'b0;
            href       <= 1'b0;
            data       <= '0;
            lo         <= '0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
            pattern_q  <= 1'b0;
        end else begin
            vsync      <= (state == ST_VSYNC);
            href       <= in_active;
            frame_done <= frame_end;
            if (even_slot) begin
                data <= pix[15:8];
                lo   <= pix[7:0];
            end else if (odd_slot) begin
                data <= lo;
            end else begin
                data <= '0;
            end
            if (frame_start) begin
                pattern_q <= test_pattern;
                underflow <= 1'b0;
            end else if (pix_rd && !pix_valid) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_camera_dvp_tx.sv
// tb/tb_camera_dvp_tx.sv - scoreboard bench for camera_dvp_tx with a 10-cycle line, 60-cycle frame
module tb_camera_dvp_tx;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        test_pattern;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_rd;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        frame_done;
    logic        underflow;

    camera_dvp_tx #(
        .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .en(en), .test_pattern(test_pattern),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_rd(pix_rd),
        .vsync(vsync), .href(href), .data(data),
        .frame_done(frame_done), .underflow(underflow)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word(input int k);
        logic [7:0] h;
        logic [7:0] l;
        h = 8'hA1 + 8'(k * 34);
        l = 8'hB2 + 8'(k * 34);
        return {h, l};
    endfunction

    // upstream FWFT source: consumes on pix_rd while valid; one pulse can be starved
    int src_idx  = 0;
    int rd_total = 0;
    int drop_at  = 13;
    assign pix_data  = word(src_idx);
    assign pix_valid = (rd_total != drop_at);

    always @(posedge pclk) begin
        if (rst_n === 1'b1 && pix_rd === 1'b1) begin
            rd_total <= rd_total + 1;
            if (pix_valid) src_idx <= src_idx + 1;
        end
    end

    logic [7:0] sb[$];
    int         exp_rd[$];
    logic       exp_uf[$];

    task automatic push_word(input logic [15:0] w);
        sb.push_back(w[15:8]);
        sb.push_back(w[7:0]);
    endtask

    logic mon_en = 1'b0;
    int   frames_done = 0;
    int   cyc = 0, last_fd = 0, have_fd = 0;
    int   run = 0, bursts = 0, vs_cnt = 0, rd_cnt = 0, overlap = 0;
    logic prev_uf = 1'b0;

    always @(negedge pclk) begin
        if (mon_en) begin
            cyc++;
            if (!rst_n) begin
                run = 0; bursts = 0; vs_cnt = 0; rd_cnt = 0; overlap = 0; have_fd = 0;
            end else begin
                if (vsync) vs_cnt++;
                if (pix_rd) rd_cnt++;
                if (vsync && href) overlap = 1;
                if (href) begin
                    run++;
                    if (sb.size() == 0) check("sb_empty", 1, 0);
                    else check("byte", data, sb.pop_front());
                end else begin
                    check("idle_data", data, 0);
                    if (run != 0) begin
                        check("href_len", run, 8);
                        bursts++;
                        run = 0;
                    end
                end
                if (frame_done) begin
                    check("vsync_len", vs_cnt, 10);
                    check("href_bursts", bursts, 3);
                    check("vsync_href_overlap", overlap, 0);
                    if (exp_rd.size() == 0) check("frame_extra", 1, 0);
                    else check("pix_rd_count", rd_cnt, exp_rd.pop_front());
                    if (exp_uf.size() != 0) check("underflow_end", prev_uf, exp_uf.pop_front());
                    check("underflow_clr", underflow, 0);
                    if (have_fd != 0) check("frame_period", cyc - last_fd, 60);
                    have_fd = 1; last_fd = cyc;
                    vs_cnt = 0; bursts = 0; rd_cnt = 0; overlap = 0;
                    frames_done++;
                end
                prev_uf = underflow;
            end
        end
    end

    task automatic wait_frames(input int n);
        int i;
        i = 0;
        while (frames_done < n && i < 300) begin
            @(negedge pclk);
            i++;
        end
        check("frame_timeout", frames_done >= n, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vsync"}, vsync, 0);
        check({tag, "_href"}, href, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_underflow"}, underflow, 0);
        check({tag, "_pix_rd"}, pix_rd, 0);
    endtask

    initial begin
        int wk;
        int seen;
        int i;
        rst_n = 1'b0; en = 1'b0; test_pattern = 1'b0;

        // frame A: source, clean
        wk = 0;
        for (int k = 0; k < 12; k++) begin push_word(word(wk)); wk++; end
        // frame B: second pixel starved
        push_word(word(wk)); wk++;
        push_word(16'h0000);
        for (int k = 2; k < 12; k++) begin push_word(word(wk)); wk++; end
        // frame C: test pattern
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 4; x++) begin
                logic [4:0] xv;
                logic [5:0] yv;
                xv = 5'(x);
                yv = 6'(y);
                push_word({xv, yv, xv});
            end
        end
        // frame D: source, en drops mid-frame
        for (int k = 0; k < 12; k++) begin push_word(word(wk)); wk++; end
        exp_rd = '{12, 12, 0, 12};
        exp_uf = '{1'b0, 1'b1, 1'b0, 1'b0};

        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check_all_zero("reset");

        mon_en = 1'b1;
        rst_n  = 1'b1;
        en     = 1'b1;

        wait_frames(1);
        test_pattern = 1'b1;
        wait_frames(2);
        test_pattern = 1'b0;
        wait_frames(3);
        repeat (30) @(negedge pclk);
        en = 1'b0;
        wait_frames(4);

        seen = 0;
        repeat (20) begin
            @(negedge pclk);
            if (vsync || href || frame_done) seen++;
        end
        check("idle_after_en_drop", seen, 0);
        check("sb_drained", sb.size(), 0);

        // frame E: interrupted by reset mid-line
        for (int k = 0; k < 12; k++) begin push_word(word(wk)); wk++; end
        en = 1'b1;
        i = 0;
        while (href !== 1'b1 && i < 100) begin
            @(negedge pclk);
            i++;
        end
        check("href_timeout", href, 1);
        repeat (3) @(negedge pclk);

        @(posedge pclk);
        #2 rst_n = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        check_all_zero("midreset");
        sb.delete();
        #1 rst_n = 1'b1;
        @(negedge pclk);
        check("vsync_after_release_1", vsync, 0);
        @(negedge pclk);
        check("vsync_after_release_2", vsync, 1);

        en = 1'b0;
        repeat (3) @(negedge pclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
